// File: rtl/nota_pkg.sv
// -----------------------------------------------------------------------------
// nota_pkg
// Shared definitions for the note/ok interface, used by the note sequence
// generator and by the adjective/adverb recognizer.
//   - note codes     : INVAL1, INVAL2, LA_BAIXO, SI_BAIXO, DO_ALTO, RE_ALTO, TERM
//   - tipo codes     : ERRO, ADJETIVO, ADJ_COMPA, ADVERBIO
//   - seq_state_t    : generator FSM state encoding
//   - raiz_invalid() : true for the two codes that can never be a root note
// -----------------------------------------------------------------------------
package nota_pkg;

   localparam logic [3:0] INVAL1   = 4'b0000;
   localparam logic [3:0] INVAL2   = 4'b1000;
   localparam logic [3:0] LA_BAIXO = 4'b1110;
   localparam logic [3:0] SI_BAIXO = 4'b1111;
   localparam logic [3:0] DO_ALTO  = 4'b0001;
   localparam logic [3:0] RE_ALTO  = 4'b0010;
   localparam logic [3:0] TERM     = 4'b0000;

   localparam logic [1:0] ERRO      = 2'b00;
   localparam logic [1:0] ADJETIVO  = 2'b01;
   localparam logic [1:0] ADJ_COMPA = 2'b10;
   localparam logic [1:0] ADVERBIO  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RRST = 3'd1,
      S_NOTE = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } seq_state_t;

   function automatic logic raiz_invalid(input logic [3:0] n);
      return (n == INVAL1) || (n == INVAL2);
   endfunction

endpackage

// File: rtl/note_seq_rom.sv
// -----------------------------------------------------------------------------
// note_seq_rom
// Purely combinational sequence table: maps a word class, branch and two root
// notes to the note at position idx, plus the index of the final note.
// Ports:
//   tipo     in  2  word class (ERRO/ADJETIVO/ADJ_COMPA/ADVERBIO)
//   variante in  1  0 = laBaixo branch, 1 = siBaixo branch
//   r0, r1   in  4  root notes
//   idx      in  3  position in the sequence
//   nota     out 4  note at position idx (TERM past the end)
//   last_idx out 3  index of the final (TERM) note
// -----------------------------------------------------------------------------
module note_seq_rom
   import nota_pkg::*;
(
   input  logic [1:0] tipo,
   input  logic       variante,
   input  logic [3:0] r0,
   input  logic [3:0] r1,
   input  logic [2:0] idx,
   output logic [3:0] nota,
   output logic [2:0] last_idx
);

   // last_idx depends on the class only; kept in its own process so the
   // FSM can use it without forming a loop through the note lookup.
   always_comb begin
      last_idx = 3'd4;
      case (tipo)
         ERRO:     last_idx = 3'd0;
         ADJETIVO: last_idx = 3'd3;
         default:  last_idx = 3'd4;
      endcase
   end

   always_comb begin
      nota = TERM;
      case (tipo)
         ADJETIVO: begin
            case (idx)
               3'd0:    nota = r0;
               3'd1:    nota = r1;
               3'd2:    nota = variante ? SI_BAIXO : LA_BAIXO;
               default: nota = TERM;
            endcase
         end
         ADJ_COMPA: begin
            case (idx)
               3'd0:    nota = r0;
               3'd1:    nota = r1;
               3'd2:    nota = variante ? SI_BAIXO : LA_BAIXO;
               3'd3:    nota = variante ? RE_ALTO : DO_ALTO;
               default: nota = TERM;
            endcase
         end
         ADVERBIO: begin
            case (idx)
               3'd0:    nota = r0;
               3'd1:    nota = r1;
               3'd2:    nota = LA_BAIXO;
               3'd3:    nota = SI_BAIXO;
               default: nota = TERM;
            endcase
         end
         default: nota = TERM;
      endcase
   end

endmodule

// File: rtl/note_seq_gen.sv
// -----------------------------------------------------------------------------
// note_seq_gen
// Transmit side of the note/ok interface. On start it captures a word class
// and two root notes and emits the note sequence the recognizer classifies as
// that class, one note per ok strobe, each followed by OK_GAP idle cycles.
//
// Handshake: start is a level request sampled only in IDLE; a request is
// accepted on the edge where state is IDLE and start=1. ok is a one-cycle
// strobe qualifying nota; nota holds through the strobe and the following gap.
//
// Optional feature macro: SEQ_RESET_EN -- inserts an RRST state that pulses
// rec_reset for one cycle before the first note (latency 2 instead of 1).
//
// Ports:
//   clock, reset  in   clock; asynchronous active-high reset
//   start         in   1  request (sampled in IDLE)
//   tipo_in       in   2  requested word class
//   variante      in   1  laBaixo (0) / siBaixo (1) branch
//   raiz0, raiz1  in   4  root notes, captured at accept
//   nota          out  4  note presented to the recognizer
//   ok            out  1  note strobe
//   busy          out  1  sequence in progress (RRST..DONE)
//   done          out  1  one-cycle completion pulse
//   raiz_err      out  1  one-cycle reject pulse (invalid root)
//   rec_reset     out  1  recognizer reset pulse (0 unless SEQ_RESET_EN)
//   dbg_state     out  3  current FSM state (seq_state_t encoding)
// Parameter: OK_GAP (1..15) idle cycles after each ok.
// -----------------------------------------------------------------------------
module note_seq_gen
   import nota_pkg::*;
#(
   parameter int unsigned OK_GAP = 2
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] tipo_in,
   input  logic       variante,
   input  logic [3:0] raiz0,
   input  logic [3:0] raiz1,
   output logic [3:0] nota,
   output logic       ok,
   output logic       busy,
   output logic       done,
   output logic       raiz_err,
   output logic       rec_reset,
   output logic [2:0] dbg_state
);

   localparam logic [3:0] GAP_LAST = 4'(OK_GAP - 1);

`ifdef SEQ_RESET_EN
   localparam seq_state_t FIRST_STATE = S_RRST;
`else
   localparam seq_state_t FIRST_STATE = S_NOTE;
`endif

   seq_state_t state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] gap_q, gap_d;
   logic [1:0] tipo_q, tipo_d;
   logic       var_q, var_d;
   logic [3:0] r0_q, r0_d;
   logic [3:0] r1_q, r1_d;
   logic [3:0] nota_q, nota_d;
   logic       ok_q, ok_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       raiz_err_q, raiz_err_d;
   logic       rec_reset_d;

   logic       accept;
   logic       raiz_bad;
   logic [3:0] rom_nota;
   logic [2:0] last_idx;

   // Capture of the request. The table is looked up with the *next* request
   // fields so the first note is ready on the accept edge.
   always_comb begin
      accept   = (state_q == S_IDLE) && start;
      raiz_bad = 1'b0;
      tipo_d   = tipo_q;
      var_d    = var_q;
      r0_d     = r0_q;
      r1_d     = r1_q;
      if (accept) begin
         tipo_d   = tipo_in;
         var_d    = variante;
         r0_d     = raiz0;
         r1_d     = raiz1;
         // erro sends only the terminator, so its roots are never checked
         raiz_bad = (tipo_in != ERRO) && (raiz_invalid(raiz0) || raiz_invalid(raiz1));
      end
   end

   note_seq_rom u_rom (
      .tipo     (tipo_d),
      .variante (var_d),
      .r0       (r0_d),
      .r1       (r1_d),
      .idx      (idx_d),
      .nota     (rom_nota),
      .last_idx (last_idx)
   );

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      gap_d      = gap_q;
      raiz_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               idx_d = 3'd0;
               if (raiz_bad) raiz_err_d = 1'b1;
               else          state_d    = FIRST_STATE;
            end
         end
         S_RRST: state_d = S_NOTE;
         S_NOTE: begin
            state_d = S_GAP;
            gap_d   = 4'd0;
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               if (idx_q == last_idx) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_NOTE;
               end
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered and decoded from the state being entered, so
   // nota only changes on the edge that enters NOTE (or clears on DONE/IDLE).
   always_comb begin
      ok_d        = (state_d == S_NOTE);
      done_d      = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
      rec_reset_d = (state_d == S_RRST);
      nota_d      = TERM;
      case (state_d)
         S_NOTE:         nota_d = rom_nota;
         S_GAP, S_RRST:  nota_d = nota_q;
         default:        nota_d = TERM;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= 3'd0;
         gap_q      <= 4'd0;
         tipo_q     <= ERRO;
         var_q      <= 1'b0;
         r0_q       <= 4'd0;
         r1_q       <= 4'd0;
         nota_q     <= TERM;
         ok_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         raiz_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         tipo_q     <= tipo_d;
         var_q      <= var_d;
         r0_q       <= r0_d;
         r1_q       <= r1_d;
         nota_q     <= nota_d;
         ok_q       <= ok_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         raiz_err_q <= raiz_err_d;
      end
   end

`ifdef SEQ_RESET_EN
   logic rec_reset_q;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) rec_reset_q <= 1'b0;
      else       rec_reset_q <= rec_reset_d;
   end
   assign rec_reset = rec_reset_q;
`else
   // RRST is never entered, so rec_reset_d is always 0 here
   logic unused_rec_reset;
   assign unused_rec_reset = rec_reset_d;
   assign rec_reset        = 1'b0;
`endif

   assign nota      = nota_q;
   assign ok        = ok_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign raiz_err  = raiz_err_q;
   assign dbg_state = state_q;

endmodule
